aes_key_expand: RTL and testbench
=================================

# aes_key_expand

Iterative AES-128 key schedule that produces the eleven 128-bit round keys (rounds 0–10), one per accepted beat. It sits directly upstream of `add_round_key` and feeds its `key` input with each round key in order. A valid/ready handshake lets the consuming round datapath stall the schedule.

## Interface
- No parameters. AES-128 only: Nk=4, Nr=10.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  one-cycle request to begin an expansion; sampled only in IDLE.
- `key_in`  input  128  cipher key, byte 0 in [127:120]; sampled on the cycle `start` is accepted.
- `rk_ready`  input  1  consumer accepts the current round key.
- `busy`  output  1  high from start acceptance until `done`.
- `rk_valid`  output  1  `round_key` and `rk_round` are valid.
- `rk_round`  output  4  round index 0–10 of the presented key.
- `round_key`  output  128  round key; word w0 in [127:96], w3 in [31:0].
- `done`  output  1  one-cycle pulse after round 10 is accepted.

## Operation
- States: IDLE, RUN, DONE.
- IDLE with `start`=1: load `key_in` into the key register, set `rk_round`=0, `busy`=1, go to RUN.
- RUN: `rk_valid`=1. A beat is accepted when `rk_valid && rk_ready`.
  - On acceptance with `rk_round`<10, the register loads the next round key and `rk_round` increments.
  - On acceptance with `rk_round`=10, go to DONE.
- DONE: for one cycle, `done`=1, `rk_valid`=0 and `busy`=0. Then go to IDLE.
- Next-key computation is combinational from the current key:
  - t = SubWord(RotWord(w3)) ^ {rcon, 24'h0}, where RotWord(w) = {w[23:0], w[31:24]}.
  - w0' = w0 ^ t; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
- SubWord uses four instances of the shared combinational 8-bit `sbox` module.
- rcon is indexed by the next round 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36. It is a small case on `rk_round`, not a stored register.
- Backpressure: while `rk_valid`=1 and `rk_ready`=0, `round_key` and `rk_round` hold bit-stable.
- `start` while not IDLE is ignored: no reload and no restart.
- `start` in the same cycle as the DONE state is ignored. The earliest new start is the cycle after DONE.
- `key_in` changes after acceptance have no effect.

## Timing
- Reset values: `busy`=0, `rk_valid`=0, `rk_round`=0, `round_key`=128'h0, `done`=0, state IDLE.
- Reset mid-operation (any state) forces all of the above on the next edge. Reset has priority over `start` and `rk_ready`.
- `start` accepted at edge T: `rk_valid`=1 with round 0 (equal to `key_in`) from cycle T+1.
- One round per accepted beat. With `rk_ready` held at 1:
  - round k is presented in cycle T+1+k;
  - round 10 is presented in T+11;
  - `done`=1 in T+12;
  - `busy` and `rk_valid` are 0 in T+12;
  - a new `start` can be accepted at T+13.
- Each stall cycle (`rk_ready`=0) delays all subsequent events by exactly one cycle.
- Outputs are registered. `round_key` has no combinational path from `rk_ready` or `start`.
- `rk_round` never exceeds 10 and does not wrap.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with `rk_ready`=1:
  - round 0 = key_in;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 2 = f2c295f27a96b9435935807a7359f67f;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - `done` pulses exactly at T+12.
- All-zero key:
  - round 1 = 62636363626363636263636362636363;
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure with the FIPS key: drop `rk_ready` for 3 cycles while round 3 is presented.
  - `round_key` and `rk_round` stay stable (round 3 = 3d80477d4716fe3e1e237e446d7a883b).
  - `done` arrives at T+15.
- `start` pulsed with a different key during round 4, and again in the DONE cycle: both are ignored and the sequence is unchanged.
- `rst` asserted while round 5 is presented:
  - next cycle, all outputs equal their reset values;
  - a new `start` then produces a clean round 0.
- Chained with `add_round_key`: state 046681e5e0cb199a48f8d37a2806264c combined with round 1 of the FIPS key gives a49c7ff2689f352b6b5bea43026a5049.

Source files
------------

// File: rtl/aes_key_expand.sv
// ----------------------------------------------------------------------------
// aes_key_expand
//
// Iterative AES-128 key schedule. After a start request it presents the
// eleven round keys (round 0 = cipher key, then rounds 1..10) one per
// accepted valid/ready beat, so the downstream round datapath can stall it.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst        synchronous active-high reset
//   start      begin an expansion (only looked at while idle)
//   key_in     128-bit cipher key, byte 0 in [127:120]
//   rk_ready   consumer accepts the presented round key
//   busy       expansion in progress (start accepted, done not yet reached)
//   rk_valid   round_key / rk_round are valid
//   rk_round   index 0..10 of the presented round key
//   round_key  presented round key, w0 in [127:96] .. w3 in [31:0]
//   done       single-cycle pulse after round 10 has been accepted
//
// Also contains sbox: the combinational AES forward S-box (8 bit in/out).
// ----------------------------------------------------------------------------

module sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX_TABLE[in_byte];

endmodule

module aes_key_expand (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    input  logic         rk_ready,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] round_key,
    output logic         done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   key_q,   key_d;
    logic [3:0]     round_q, round_d;

    // ------------------------------------------------------------------
    // Next round key, purely combinational from the current key register
    // ------------------------------------------------------------------
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_word;
    logic [31:0]  sub_word;
    logic [7:0]   rcon;
    logic [31:0]  t_word;
    logic [31:0]  nw0, nw1, nw2, nw3;
    logic [127:0] next_key;

    assign w0 = key_q[127:96];
    assign w1 = key_q[95:64];
    assign w2 = key_q[63:32];
    assign w3 = key_q[31:0];

    // RotWord: cyclic left rotate by one byte
    assign rot_word = {w3[23:0], w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_subword
            sbox u_sbox (
                .in_byte  (rot_word[gi*8 +: 8]),
                .out_byte (sub_word[gi*8 +: 8])
            );
        end
    endgenerate

    // rcon for the round being produced (rk_round + 1)
    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    assign t_word   = sub_word ^ {rcon, 24'h000000};
    assign nw0      = w0 ^ t_word;
    assign nw1      = w1 ^ nw0;
    assign nw2      = w2 ^ nw1;
    assign nw3      = w3 ^ nw2;
    assign next_key = {nw0, nw1, nw2, nw3};

    // ------------------------------------------------------------------
    // Control FSM: next state / next register contents
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = 4'd0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // rk_valid is implied by ST_RUN, so rk_ready alone accepts
                if (rk_ready) begin
                    if (round_q == 4'd10) begin
                        state_d = ST_DONE;
                    end else begin
                        key_d   = next_key;
                        round_d = round_q + 4'd1;
                    end
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= 4'd0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    // Outputs decode straight from flops; nothing reaches them from
    // rk_ready or start within the same cycle.
    assign busy      = (state_q == ST_RUN);
    assign rk_valid  = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign rk_round  = round_q;
    assign round_key = key_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// ----------------------------------------------------------------------------
// tb_aes_key_expand
//
// Directed bench for aes_key_expand: FIPS-197 and all-zero keys, a 3-cycle
// stall on round 3, ignored start requests, and a mid-run reset. Expected
// round keys are the published FIPS-197 Appendix A values.
// ----------------------------------------------------------------------------

module tb_aes_key_expand;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] round_key;
    logic         done;

    int n_cmp;
    int n_err;

    logic [127:0] fips_rk [0:10];
    logic [127:0] obs_key [0:10];
    int           obs_done;

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY  = 128'h0;
    localparam logic [127:0] ARK_STATE = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] ARK_OUT   = 128'ha49c7ff2689f352b6b5bea43026a5049;

    aes_key_expand dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .key_in    (key_in),
        .rk_ready  (rk_ready),
        .busy      (busy),
        .rk_valid  (rk_valid),
        .rk_round  (rk_round),
        .round_key (round_key),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Runs one expansion starting on the next edge. Inputs change and
    // outputs are sampled on the falling edge; cycle 1 is the one right
    // after the accepting edge. Optional stall on round stall_at for
    // stall_n cycles; optional extra start pulses in round 4 and in DONE.
    task automatic run_expand(input logic [127:0] k, input int stall_at,
                              input int stall_n, input bit poke);
        int           cyc;
        int           r;
        int           stalls_left;
        bit           seen_done;
        bit           poked;
        logic [127:0] held;
        for (int i = 0; i < 11; i++) obs_key[i] = '0;
        obs_done    = -1;
        r           = 0;
        stalls_left = stall_n;
        seen_done   = 1'b0;
        poked       = 1'b0;
        held        = '0;
        key_in      = k;
        start       = 1'b1;
        rk_ready    = 1'b1;
        @(negedge clk);
        cyc    = 1;
        start  = 1'b0;
        key_in = ~k;
        while (!seen_done && cyc < 40) begin
            start    = 1'b0;
            rk_ready = 1'b1;
            if (done) begin
                seen_done = 1'b1;
                obs_done  = cyc;
                check("done_rk_valid", rk_valid, 0);
                check("done_busy", busy, 0);
            end else if (rk_valid) begin
                check($sformatf("round_idx_c%0d", cyc), rk_round, r);
                check($sformatf("busy_c%0d", cyc), busy, 1);
                if (int'(rk_round) == stall_at && stalls_left < stall_n)
                    check($sformatf("stall_stable_c%0d", cyc), round_key, held);
                obs_key[rk_round] = round_key;
                if (int'(rk_round) == stall_at && stalls_left > 0) begin
                    held     = round_key;
                    rk_ready = 1'b0;
                    stalls_left--;
                end else begin
                    r++;
                end
                if (poke && !poked && rk_round == 4'd4) begin
                    start  = 1'b1;
                    key_in = {$urandom, $urandom, $urandom, $urandom};
                    poked  = 1'b1;
                end
            end
            if (!seen_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        check("done_seen", {127'b0, seen_done}, 1);
        if (poke) begin
            start  = 1'b1;
            key_in = {$urandom, $urandom, $urandom, $urandom};
        end
        @(negedge clk);
        start = 1'b0;
        check("post_done_busy", busy, 0);
        check("post_done_valid", rk_valid, 0);
        check("post_done_done", done, 0);
        @(negedge clk);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;

        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_valid", rk_valid, 0);
        check("rst_round", rk_round, 0);
        check("rst_key", round_key, 0);
        check("rst_done", done, 0);
        $display("step reset: busy=%0b valid=%0b round=%0d", busy, rk_valid, rk_round);

        // FIPS-197 key, no stalls
        run_expand(FIPS_KEY, -1, 0, 1'b0);
        for (int i = 0; i < 11; i++)
            check($sformatf("fips_rk%0d", i), obs_key[i], fips_rk[i]);
        check("fips_done_cycle", obs_done, 12);
        check("ark_chain", ARK_STATE ^ obs_key[1], ARK_OUT);
        $display("step fips: rk10=%h done_cycle=%0d", obs_key[10], obs_done);

        // All-zero key
        run_expand(ZERO_KEY, -1, 0, 1'b0);
        check("zero_rk1", obs_key[1], 128'h62636363626363636263636362636363);
        check("zero_rk10", obs_key[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        check("zero_done_cycle", obs_done, 12);
        $display("step zero: rk1=%h rk10=%h", obs_key[1], obs_key[10]);

        // Backpressure: 3 stall cycles on round 3
        run_expand(FIPS_KEY, 3, 3, 1'b0);
        check("stall_rk3", obs_key[3], fips_rk[3]);
        check("stall_rk10", obs_key[10], fips_rk[10]);
        check("stall_done_cycle", obs_done, 15);
        $display("step stall: rk3=%h done_cycle=%0d", obs_key[3], obs_done);

        // Ignored start pulses in round 4 and in the DONE cycle
        run_expand(FIPS_KEY, -1, 0, 1'b1);
        for (int i = 0; i < 11; i++)
            check($sformatf("poke_rk%0d", i), obs_key[i], fips_rk[i]);
        check("poke_done_cycle", obs_done, 12);
        $display("step poke: rk4=%h done_cycle=%0d", obs_key[4], obs_done);

        // Reset while round 5 is presented
        key_in   = FIPS_KEY;
        start    = 1'b1;
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && rk_round != 4'd5; i++) @(negedge clk);
        check("mid_reached_r5", rk_round, 5);
        check("mid_rk5", round_key, fips_rk[5]);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", rk_valid, 0);
        check("mid_rst_round", rk_round, 0);
        check("mid_rst_key", round_key, 0);
        check("mid_rst_done", done, 0);
        $display("step midreset: busy=%0b valid=%0b round=%0d", busy, rk_valid, rk_round);
        run_expand(FIPS_KEY, -1, 0, 1'b0);
        check("restart_rk0", obs_key[0], fips_rk[0]);
        check("restart_rk10", obs_key[10], fips_rk[10]);
        check("restart_done_cycle", obs_done, 12);
        $display("step restart: rk0=%h done_cycle=%0d", obs_key[0], obs_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
